// File: rtl/router_fifo.sv
// Per-destination output FIFO with packet-boundary tracking; data_out is registered, so a read accepted at an edge shows its byte right after that edge.
// There is no backpressure: a write while full is dropped, a read while empty is ignored, and soft_reset flushes the FIFO ahead of both.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             we,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             re,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             rd_busy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [6:0]     rd_cnt;
    logic           wr_en;
    logic           rd_en;
    logic [WIDTH:0] rd_entry;

    // The extra MSB on each pointer separates full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en    = we && !full && !soft_reset;
    assign rd_en    = re && !empty && !soft_reset;
    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign rd_busy  = (rd_cnt != 7'd0);

    // Storage is never cleared; a flush only resets the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // A header byte loads the payload length plus one for the trailing parity byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt   <= 7'd0;
            data_out <= '0;
        end else if (soft_reset) begin
            rd_cnt   <= 7'd0;
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= rd_entry[WIDTH-1:0];
            if (rd_entry[WIDTH]) begin
                rd_cnt <= {1'b0, rd_entry[7:2]} + 7'd1;
            end else if (rd_cnt != 7'd0) begin
                rd_cnt <= rd_cnt - 7'd1;
            end
        end else if (rd_cnt == 7'd0) begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed and random checks of router_fifo against a queue-based packet model.
module tb_router_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       we = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       re = 1'b0;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       rd_busy;

    router_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .we         (we),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .re         (re),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .rd_busy    (rd_busy)
    );

    always #5 clk = ~clk;

    // Reference model: queue of {marker, byte}, remaining-byte count, last output byte.
    logic [8:0] q[$];
    int         m_cnt;
    logic [7:0] m_dout;
    int         n_cmp = 0;
    int         n_err = 0;
    string      phase = "reset";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("empty",    {31'd0, empty},   {31'd0, q.size() == 0});
        chk("full",     {31'd0, full},    {31'd0, q.size() == DEPTH});
        chk("rd_busy",  {31'd0, rd_busy}, {31'd0, m_cnt != 0});
        chk("data_out", {24'd0, data_out}, {24'd0, m_dout});
    endtask

    task automatic model_clear();
        q.delete();
        m_cnt  = 0;
        m_dout = 8'h00;
    endtask

    task automatic step(input logic w, input logic l, input logic [7:0] d,
                        input logic r, input logic sr);
        int         sz;
        logic       wa;
        logic       ra;
        logic [8:0] e;
        we = w; lfd_state = l; data_in = d; re = r; soft_reset = sr;
        @(posedge clk);
        #1;
        if (sr) begin
            model_clear();
        end else begin
            sz = q.size();
            wa = w && (sz < DEPTH);
            ra = r && (sz > 0);
            if (ra) begin
                e = q.pop_front();
                m_dout = e[7:0];
                if (e[8])           m_cnt = int'(e[7:2]) + 1;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (wa) q.push_back({l, d});
        end
        chk_model();
    endtask

    task automatic wr(input logic l, input logic [7:0] d); step(1'b1, l, d, 1'b0, 1'b0); endtask
    task automatic rd();   step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); endtask
    task automatic idle(); step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); endtask

    initial begin
        model_clear();
        // Asynchronous reset values before any clock edge.
        #2;
        chk("empty",    {31'd0, empty},   32'd1);
        chk("full",     {31'd0, full},    32'd0);
        chk("rd_busy",  {31'd0, rd_busy}, 32'd0);
        chk("data_out", {24'd0, data_out}, 32'd0);
        #10 resetn = 1'b1;

        phase = "basic";
        wr(1'b1, 8'h0C);
        chk("empty_after_wr", {31'd0, empty}, 32'd0);
        wr(1'b0, 8'hA1); wr(1'b0, 8'hA2); wr(1'b0, 8'hA3); wr(1'b0, 8'h5A);
        rd(); chk("hdr", {24'd0, data_out}, 32'h0C);
        rd(); rd(); rd();
        chk("busy_before_par", {31'd0, rd_busy}, 32'd1);
        rd(); chk("par", {24'd0, data_out}, 32'h5A);
        chk("busy_after_par", {31'd0, rd_busy}, 32'd0);
        idle(); chk("blank", {24'd0, data_out}, 32'h00);
        chk("empty_end", {31'd0, empty}, 32'd1);

        phase = "overflow";
        for (int i = 1; i <= 17; i++) begin
            wr(1'b0, 8'(i));
            if (i == 15) chk("not_full_15", {31'd0, full}, 32'd0);
            if (i == 16) chk("full_16", {31'd0, full}, 32'd1);
        end
        for (int i = 1; i <= 16; i++) begin
            rd();
            chk("order", {24'd0, data_out}, 32'(i));
        end
        chk("empty_drained", {31'd0, empty}, 32'd1);
        idle();

        phase = "simul";
        for (int i = 0; i < 8; i++) wr(1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 8'(8'h80 + i), 1'b1, 1'b0);
            chk("keep8_full",  {31'd0, full},  32'd0);
            chk("keep8_empty", {31'd0, empty}, 32'd0);
        end
        for (int i = 0; i < 8; i++) rd();
        chk("simul_last", {24'd0, data_out}, 32'h93);
        idle();

        phase = "softrst";
        wr(1'b1, 8'h28);
        for (int i = 0; i < 6; i++) wr(1'b0, 8'(8'hB0 + i));
        rd();
        idle(); chk("hold", {24'd0, data_out}, 32'h28);
        rd(); rd();
        step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b1);
        chk("sr_empty", {31'd0, empty},   32'd1);
        chk("sr_busy",  {31'd0, rd_busy}, 32'd0);
        chk("sr_dout",  {24'd0, data_out}, 32'h00);
        idle(); chk("sr_wr_dropped", {31'd0, empty}, 32'd1);

        phase = "asyncrst";
        for (int i = 0; i < DEPTH; i++) wr(1'b0, 8'(8'hC0 + i));
        we = 1'b0;
        #3 resetn = 1'b0;
        #1;
        chk("ar_full",  {31'd0, full},    32'd0);
        chk("ar_empty", {31'd0, empty},   32'd1);
        chk("ar_dout",  {24'd0, data_out}, 32'h00);
        model_clear();
        #2 resetn = 1'b1;

        phase = "zerolen";
        wr(1'b1, 8'h01); wr(1'b0, 8'h77);
        rd(); chk("zl_busy", {31'd0, rd_busy}, 32'd1);
        rd(); chk("zl_par",  {24'd0, data_out}, 32'h77);
        chk("zl_done", {31'd0, rd_busy}, 32'd0);
        idle(); chk("zl_blank", {24'd0, data_out}, 32'h00);

        phase = "random";
        for (int i = 0; i < 800; i++) begin
            logic w, r, l, sr;
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 50);
            l  = ($urandom_range(0, 5) == 0);
            sr = ($urandom_range(0, 99) == 0);
            step(w, l, 8'($urandom), r, sr);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination output FIFO of the 1x3 packet router, written by the input datapath under the synchroniser's one-hot write enable and drained by the destination client. The synchroniser derives its valid-out and full indications from `empty` and `full`, and it drives `soft_reset` after a client ignores valid data for 30 cycles. Each entry stores a byte plus a header-marker bit. The read side uses the marker to track packet boundaries and to blank `data_out` between packets.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥2.
- `WIDTH`, 8, data byte width; header layout is fixed for `WIDTH`=8.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `soft_reset`  in  1  synchronous flush from the synchroniser; active high.
- `we`  in  1  write request; this FIFO's bit of the synchroniser's one-hot `we`.
- `lfd_state`  in  1  marks the byte on `data_in` as a packet header.
- `data_in`  in  WIDTH  write data.
- `re`  in  1  read request from the destination client.
- `data_out`  out  WIDTH  registered read data.
- `empty`  out  1  no stored entries.
- `full`  out  1  DEPTH entries stored.
- `rd_busy`  out  1  packet partially read: remaining-byte count ≠ 0.

## Operation
- Storage: DEPTH × (WIDTH+1). Each entry is {lfd_state, data_in}.
- Pointers: `wr_ptr` and `rd_ptr`, each log2(DEPTH)+1 bits. The low bits index the storage and wrap naturally. The MSB is the wrap flag.
- `empty` = (wr_ptr == rd_ptr). `full` = MSBs differ and low bits are equal. Both are combinational from the registered pointers.
- Write is accepted when `we` && !`full`. The accepted entry is stored at wr_ptr[low], and wr_ptr increments.
  - A write while `full` is dropped. This holds even if a read is accepted in the same cycle.
- Read is accepted when `re` && !`empty`. `data_out` loads mem[rd_ptr][WIDTH-1:0], and rd_ptr increments.
  - A read while `empty` is ignored.
- A simultaneous accepted read and write is legal at any occupancy except full (write dropped) and empty (read ignored, write accepted).
- Packet counter `rd_cnt`, 7 bits:
  - On an accepted read of an entry with marker = 1: `rd_cnt` ← data[7:2] + 1 (payload length + parity). Range 1..64.
  - On an accepted read of an entry with marker = 0 and `rd_cnt` ≠ 0: `rd_cnt` ← `rd_cnt` − 1.
  - An accepted read of a marker-0 entry with `rd_cnt` = 0 (orphan byte) is output normally, and `rd_cnt` stays 0.
- `data_out` blanking: in a cycle with no accepted read and `rd_cnt` = 0, `data_out` ← 0. With `rd_cnt` ≠ 0, `data_out` holds its last value.
- `rd_busy` = (`rd_cnt` ≠ 0).
- Priority: `resetn` low > `soft_reset` > read/write.
  - `soft_reset` clears both pointers, `rd_cnt` and `data_out` to 0.
  - Any write or read in a soft-reset cycle is discarded.
  - Storage contents are not cleared; they are unreachable after the pointers clear.

## Timing
- Reset values (`resetn` low, asynchronous): wr_ptr = rd_ptr = 0, `rd_cnt` = 0, `data_out` = 0, `empty` = 1, `full` = 0, `rd_busy` = 0.
- Write-to-flag latency: a write accepted at edge N gives `empty` = 0 immediately after edge N. A write made visible at edge N is readable at edge N+1.
- Read latency: a read accepted at edge N presents the byte on `data_out` immediately after edge N.
- After `soft_reset` sampled high at edge N: `empty` = 1, `full` = 0, `data_out` = 0 after edge N.
- Pointer wrap: after 2·DEPTH writes and 2·DEPTH reads, both pointers return to 0. No flag glitch is permitted at the wrap.
- Parity-byte read (`rd_cnt` 1→0) at edge N: `data_out` shows parity after edge N. `data_out` = 0 after edge N+1 if no read occurs at N+1.

## Test plan
- Reset and basic packet:
  - Stimulus: write header 0x0C (len 3, lfd=1), 3 payload bytes, parity; then read continuously.
  - Required: `data_out` sequence 0x0C, payload, parity. `rd_cnt` sequence 4, 3, 2, 1, 0. `data_out` = 0 one cycle after the parity read. `empty` = 1 at the end.
- Full/overflow:
  - Stimulus: write 17 bytes with `re` = 0.
  - Required: `full` = 1 after the 16th write. The 17th byte is dropped. 16 reads return bytes 1..16 in order.
- Simultaneous:
  - Stimulus: at occupancy 8, assert `we` and `re` together for 20 cycles.
  - Required: occupancy stays 8, data order is preserved, and both pointers wrap with no `full`/`empty` toggle.
- Soft reset mid-packet:
  - Stimulus: header len 10 read, 2 payload bytes read, then `soft_reset` pulsed with `we` high.
  - Required: next cycle `empty` = 1, `rd_busy` = 0, `data_out` = 0, and the write is discarded.
- Async reset:
  - Stimulus: drop `resetn` between clock edges while the FIFO is full.
  - Required: `full` = 0, `empty` = 1 and `data_out` = 0 without waiting for a clock edge.
- Zero-length packet:
  - Stimulus: header 0x01 (len 0), then parity.
  - Required: `rd_cnt` = 1 after the header read and 0 after the parity read; `data_out` blanks on the following idle cycle.
